// File: rtl/game_flow_ctrl_pkg.sv
// Shared game-flow definitions: FSM state codes, screen geometry constants
// (also consumed by World and the renderer) and datapath widths.
package game_flow_ctrl_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned X_W     = 11;
    localparam int unsigned Y_W     = 10;
    localparam int unsigned VIEW_W  = 33;
    localparam int unsigned LIVES_W = 2;
    localparam int unsigned TIME_W  = 9;
    localparam int unsigned HOLD_W  = 8;

    // Screen geometry
    localparam int unsigned SCREEN_HALF_W    = 320;
    localparam int unsigned SCREEN_PIT_Y     = 480;
    localparam int unsigned SCREEN_VIEW_INIT = 640;
    localparam int unsigned SCREEN_VIEW_MAX  = 3392;

    typedef enum logic [STATE_W-1:0] {
        ST_TITLE   = 3'd0,
        ST_RESPAWN = 3'd1,
        ST_PLAYING = 3'd2,
        ST_DYING   = 3'd3,
        ST_CLEAR   = 3'd4,
        ST_OVER    = 3'd5
    } state_t;

    // World is held in reset whenever no level is live
    function automatic logic world_run(input state_t s);
        return !(s inside {ST_TITLE, ST_RESPAWN, ST_OVER});
    endfunction

endpackage

// File: rtl/game_flow_ctrl_tick_counter.sv
// Hold counter: counts enable pulses, clears on request, flags the pulse that
// reaches the terminal count.
//   clk, rst   : clock, synchronous active-low reset
//   clear      : zero the count (wins over enable)
//   en         : count one pulse
//   terminal   : number of pulses to reach
//   done_c     : combinational, high on the pulse that completes the count
module game_flow_ctrl_tick_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] terminal,
    output logic             done_c
);

    logic [WIDTH-1:0] count_q;

    // Pulse counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign done_c = en && (count_q == terminal - WIDTH'(1));

endmodule

// File: rtl/game_flow_ctrl.sv
// Game flow controller: title / respawn / play / death / clear / game-over
// sequencing, lives, level timer, camera and button gating.
//   clk, rst                     : clock, synchronous active-low reset
//   tick_10                      : one-cycle game-tick enable
//   start                        : start button (level, edge-detected)
//   jump_in/left_in/right_in     : raw buttons
//   mario_x, mario_y             : Mario position from World
//   mario_dead, flag_reached     : enemy-kill and goal flags
//   world_rst                    : active-low reset to World
//   jump/left/right              : buttons passed through only while playing
//   view, lives, time_left       : camera right edge, lives, level timer
//   state                        : FSM state code
module game_flow_ctrl
    import game_flow_ctrl_pkg::*;
#(
    parameter int unsigned LIVES_INIT  = 3,
    parameter int unsigned TIME_INIT   = 400,
    parameter int unsigned DEATH_TICKS = 20,
    parameter int unsigned CLEAR_TICKS = 30,
    parameter int unsigned VIEW_INIT   = SCREEN_VIEW_INIT,
    parameter int unsigned VIEW_MAX    = SCREEN_VIEW_MAX,
    parameter int unsigned PIT_Y       = SCREEN_PIT_Y
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_10,
    input  logic               start,
    input  logic               jump_in,
    input  logic               left_in,
    input  logic               right_in,
    input  logic [X_W-1:0]     mario_x,
    input  logic [Y_W-1:0]     mario_y,
    input  logic               mario_dead,
    input  logic               flag_reached,
    output logic               world_rst,
    output logic               jump,
    output logic               left,
    output logic               right,
    output logic [VIEW_W-1:0]  view,
    output logic [LIVES_W-1:0] lives,
    output logic [TIME_W-1:0]  time_left,
    output logic [STATE_W-1:0] state
);

    localparam logic [LIVES_W-1:0] LIVES_V     = LIVES_W'(LIVES_INIT);
    localparam logic [TIME_W-1:0]  TIME_V      = TIME_W'(TIME_INIT);
    localparam logic [VIEW_W-1:0]  VIEW_INIT_V = VIEW_W'(VIEW_INIT);
    localparam logic [VIEW_W-1:0]  VIEW_MAX_V  = VIEW_W'(VIEW_MAX);
    localparam logic [VIEW_W-1:0]  HALF_W_V    = VIEW_W'(SCREEN_HALF_W);
    localparam logic [Y_W-1:0]     PIT_Y_V     = Y_W'(PIT_Y);
    localparam logic [HOLD_W-1:0]  DEATH_T     = HOLD_W'(DEATH_TICKS);
    localparam logic [HOLD_W-1:0]  CLEAR_T     = HOLD_W'(CLEAR_TICKS);

    state_t               state_q, state_nxt;
    logic                 world_rst_q, world_rst_nxt;
    logic [LIVES_W-1:0]   lives_q, lives_nxt;
    logic [TIME_W-1:0]    time_q, time_nxt;
    logic [VIEW_W-1:0]    view_q, view_nxt;
    logic                 start_prev_q;

    logic                 start_edge;
    logic                 dies;
    logic [VIEW_W-1:0]    view_target;
    logic                 hold_en;
    logic                 hold_done;
    logic [HOLD_W-1:0]    hold_terminal;

    assign start_edge    = start && !start_prev_q;
    assign view_target   = VIEW_W'(mario_x) + HALF_W_V;
    assign dies          = mario_dead || (mario_y >= PIT_Y_V) || (time_q == '0);
    assign hold_en       = tick_10 && (state_q inside {ST_DYING, ST_CLEAR});
    assign hold_terminal = (state_q == ST_DYING) ? DEATH_T : CLEAR_T;

    // Death / level-clear hold timer, restarted on every state change
    game_flow_ctrl_tick_counter #(
        .WIDTH (HOLD_W)
    ) u_tick_counter (
        .clk      (clk),
        .rst      (rst),
        .clear    (state_nxt != state_q),
        .en       (hold_en),
        .terminal (hold_terminal),
        .done_c   (hold_done)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_TITLE;
            world_rst_q  <= 1'b0;
            lives_q      <= LIVES_V;
            time_q       <= TIME_V;
            view_q       <= VIEW_INIT_V;
            start_prev_q <= 1'b1;
        end else begin
            state_q      <= state_nxt;
            world_rst_q  <= world_rst_nxt;
            lives_q      <= lives_nxt;
            time_q       <= time_nxt;
            view_q       <= view_nxt;
            start_prev_q <= start;
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_nxt = state_q;
        lives_nxt = lives_q;
        time_nxt  = time_q;
        view_nxt  = view_q;

        case (state_q)
            ST_TITLE, ST_OVER: begin
                if (start_edge) begin
                    state_nxt = ST_RESPAWN;
                    lives_nxt = LIVES_V;
                end
            end
            ST_RESPAWN: begin
                state_nxt = ST_PLAYING;
                view_nxt  = VIEW_INIT_V;
                time_nxt  = TIME_V;
            end
            ST_PLAYING: begin
                if (tick_10 && (time_q != '0)) begin
                    time_nxt = time_q - TIME_W'(1);
                end
                // Camera only moves right
                if (view_target > view_q) begin
                    view_nxt = (view_target > VIEW_MAX_V) ? VIEW_MAX_V : view_target;
                end
                // Reaching the flag beats a simultaneous death
                if (flag_reached) begin
                    state_nxt = ST_CLEAR;
                end else if (dies) begin
                    state_nxt = ST_DYING;
                    if (lives_q != '0) begin
                        lives_nxt = lives_q - LIVES_W'(1);
                    end
                end
            end
            ST_DYING: begin
                if (hold_done) begin
                    state_nxt = (lives_q != '0) ? ST_RESPAWN : ST_OVER;
                end
            end
            ST_CLEAR: begin
                if (hold_done) begin
                    state_nxt = ST_TITLE;
                end
            end
            default: begin
                state_nxt = ST_TITLE;
            end
        endcase

        world_rst_nxt = world_run(state_nxt);
    end

    assign world_rst = world_rst_q;
    assign view      = view_q;
    assign lives     = lives_q;
    assign time_left = time_q;
    assign state     = state_q;

    // Buttons reach World only during play, with no added latency
    assign jump  = jump_in  && (state_q == ST_PLAYING);
    assign left  = left_in  && (state_q == ST_PLAYING);
    assign right = right_in && (state_q == ST_PLAYING);

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Testbench for game_flow_ctrl: directed scenarios plus randomized play,
// checked every cycle against a behavioural model of the game rules.
module tb_game_flow_ctrl;

    localparam int LIVES_INIT  = 3;
    localparam int TIME_INIT   = 400;
    localparam int DEATH_TICKS = 20;
    localparam int CLEAR_TICKS = 30;
    localparam int VIEW_INIT   = 640;
    localparam int PIT_Y       = 480;
    // mario_x is 11 bits (max 2047), so the clamp is lowered to be reachable
    localparam int VIEW_MAX    = 2000;

    localparam int S_TITLE   = 0;
    localparam int S_RESPAWN = 1;
    localparam int S_PLAYING = 2;
    localparam int S_DYING   = 3;
    localparam int S_CLEAR   = 4;
    localparam int S_OVER    = 5;

    logic        clk = 1'b0;
    logic        rst, tick_10, start, jump_in, left_in, right_in;
    logic        mario_dead, flag_reached;
    logic [10:0] mario_x;
    logic [9:0]  mario_y;
    logic        world_rst, jump, left, right;
    logic [32:0] view;
    logic [1:0]  lives;
    logic [8:0]  time_left;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;
    int tick_pct = 0;

    // Reference model of the game rules
    int m_state, m_lives, m_time, m_view, m_hold;
    bit m_prev;

    game_flow_ctrl #(
        .LIVES_INIT  (LIVES_INIT),
        .TIME_INIT   (TIME_INIT),
        .DEATH_TICKS (DEATH_TICKS),
        .CLEAR_TICKS (CLEAR_TICKS),
        .VIEW_INIT   (VIEW_INIT),
        .VIEW_MAX    (VIEW_MAX),
        .PIT_Y       (PIT_Y)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick_10      (tick_10),
        .start        (start),
        .jump_in      (jump_in),
        .left_in      (left_in),
        .right_in     (right_in),
        .mario_x      (mario_x),
        .mario_y      (mario_y),
        .mario_dead   (mario_dead),
        .flag_reached (flag_reached),
        .world_rst    (world_rst),
        .jump         (jump),
        .left         (left),
        .right        (right),
        .view         (view),
        .lives        (lives),
        .time_left    (time_left),
        .state        (state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock edge of the game rules, applied to the inputs now present
    task automatic model_clock();
        int  ns;
        bit  sedge;
        int  target;
        bit  died;
        if (!rst) begin
            m_state = S_TITLE;
            m_lives = LIVES_INIT;
            m_time  = TIME_INIT;
            m_view  = VIEW_INIT;
            m_hold  = 0;
            m_prev  = 1'b1;
            return;
        end
        sedge  = start && !m_prev;
        m_prev = start;
        ns     = m_state;
        case (m_state)
            S_TITLE, S_OVER: begin
                if (sedge) begin
                    ns      = S_RESPAWN;
                    m_lives = LIVES_INIT;
                end
            end
            S_RESPAWN: begin
                ns     = S_PLAYING;
                m_view = VIEW_INIT;
                m_time = TIME_INIT;
            end
            S_PLAYING: begin
                died = mario_dead || (int'(mario_y) >= PIT_Y) || (m_time == 0);
                if (tick_10 && m_time > 0) m_time = m_time - 1;
                target = int'(mario_x) + 320;
                if (target > m_view) m_view = (target > VIEW_MAX) ? VIEW_MAX : target;
                if (flag_reached) begin
                    ns = S_CLEAR;
                end else if (died) begin
                    ns = S_DYING;
                    if (m_lives > 0) m_lives = m_lives - 1;
                end
            end
            S_DYING: begin
                if (tick_10) m_hold = m_hold + 1;
                if (m_hold == DEATH_TICKS) ns = (m_lives != 0) ? S_RESPAWN : S_OVER;
            end
            S_CLEAR: begin
                if (tick_10) m_hold = m_hold + 1;
                if (m_hold == CLEAR_TICKS) ns = S_TITLE;
            end
            default: ns = S_TITLE;
        endcase
        if (ns != m_state) m_hold = 0;
        m_state = ns;
    endtask

    // One cycle: random buttons/tick, check gating, clock, check registers
    task automatic step();
        bit play;
        bit wr;
        jump_in  = 1'($urandom_range(0, 1));
        left_in  = 1'($urandom_range(0, 1));
        right_in = 1'($urandom_range(0, 1));
        tick_10  = ($urandom_range(0, 99) < 32'(tick_pct));
        #1;
        play = (m_state == S_PLAYING);
        check("jump_gate",  33'(jump),  33'(play && jump_in));
        check("left_gate",  33'(left),  33'(play && left_in));
        check("right_gate", 33'(right), 33'(play && right_in));
        model_clock();
        @(posedge clk);
        #1;
        wr = !(m_state == S_TITLE || m_state == S_RESPAWN || m_state == S_OVER);
        check("state",     33'(state),     33'(m_state));
        check("lives",     33'(lives),     33'(m_lives));
        check("time_left", 33'(time_left), 33'(m_time));
        check("view",      view,           33'(m_view));
        check("world_rst", 33'(world_rst), 33'(wr));
    endtask

    task automatic wait_state(input int target, input int budget);
        for (int i = 0; i < budget && m_state != target; i++) step();
        check("reach_state", 33'(state), 33'(target));
    endtask

    initial begin
        rst = 1'b0; start = 1'b1; tick_10 = 1'b0;
        jump_in = 1'b0; left_in = 1'b0; right_in = 1'b0;
        mario_x = '0; mario_y = '0; mario_dead = 1'b0; flag_reached = 1'b0;
        @(posedge clk);
        #1;
        model_clock();

        // Reset with start held
        repeat (3) step();
        check("rst_state", 33'(state), 33'(S_TITLE));
        check("rst_wrst",  33'(world_rst), 33'(0));
        check("rst_lives", 33'(lives), 33'(LIVES_INIT));
        check("rst_time",  33'(time_left), 33'(TIME_INIT));
        check("rst_view",  view, 33'(VIEW_INIT));
        rst = 1'b1;
        repeat (4) step();
        check("held_start_no_game", 33'(state), 33'(S_TITLE));

        // Start edge: one RESPAWN cycle then PLAYING
        start = 1'b0; step();
        start = 1'b1; step();
        check("respawn_state", 33'(state), 33'(S_RESPAWN));
        check("respawn_wrst",  33'(world_rst), 33'(0));
        step();
        check("play_state", 33'(state), 33'(S_PLAYING));
        check("play_lives", 33'(lives), 33'(3));
        check("play_time",  33'(time_left), 33'(400));
        check("play_view",  view, 33'(640));

        // Camera follows right, never left, clamps
        tick_pct = 0;
        mario_x = 11'd320;  step(); check("cam_320",  view, 33'(640));
        mario_x = 11'd700;  step(); check("cam_700",  view, 33'(1020));
        mario_x = 11'd400;  step(); check("cam_back", view, 33'(1020));
        mario_x = 11'd2047; step(); check("cam_clamp", view, 33'(VIEW_MAX));

        // Random play without events
        tick_pct = 30;
        repeat (40) begin
            mario_x = 11'($urandom_range(0, 2047));
            mario_y = 10'($urandom_range(0, 479));
            step();
        end

        // Flag beats death, then clear hold back to TITLE
        mario_dead = 1'b1; flag_reached = 1'b1; step();
        check("flag_wins", 33'(state), 33'(S_CLEAR));
        check("flag_lives", 33'(lives), 33'(3));
        mario_dead = 1'b0; flag_reached = 1'b0; tick_pct = 40;
        wait_state(S_TITLE, 400);

        // Three pit deaths to game over
        start = 1'b0; step();
        start = 1'b1; step(); step();
        for (int d = 0; d < 3; d++) begin
            mario_y = (d == 0) ? 10'd480 : 10'($urandom_range(480, 1023));
            step();
            check("pit_dying", 33'(state), 33'(S_DYING));
            check("pit_lives", 33'(lives), 33'(2 - d));
            mario_y = '0;
            wait_state((d < 2) ? S_PLAYING : S_OVER, 1000);
        end
        repeat (5) step();
        check("over_held_start", 33'(state), 33'(S_OVER));
        start = 1'b0; step();
        start = 1'b1; step();
        check("over_restart", 33'(state), 33'(S_RESPAWN));
        check("over_lives",   33'(lives), 33'(3));
        step();

        // Timer runs out
        tick_pct = 100; mario_x = '0;
        for (int i = 0; i < 500 && m_time != 0; i++) step();
        check("timeout_zero",  33'(time_left), 33'(0));
        check("timeout_still", 33'(state), 33'(S_PLAYING));
        step();
        check("timeout_dying", 33'(state), 33'(S_DYING));

        // Reset in the middle of the death hold
        repeat (5) step();
        check("mid_hold", 33'(state), 33'(S_DYING));
        rst = 1'b0; step(); rst = 1'b1;
        check("midrst_state", 33'(state), 33'(S_TITLE));
        check("midrst_lives", 33'(lives), 33'(LIVES_INIT));
        check("midrst_view",  view, 33'(VIEW_INIT));

        // Fully random play with occasional resets
        tick_pct = 50;
        for (int i = 0; i < 2500; i++) begin
            rst = ($urandom_range(0, 999) != 0);
            if ($urandom_range(0, 19) == 0) start = ~start;
            mario_dead   = ($urandom_range(0, 99) < 2);
            flag_reached = ($urandom_range(0, 99) < 1);
            mario_x      = 11'($urandom_range(0, 2047));
            mario_y      = ($urandom_range(0, 19) == 0) ? 10'($urandom_range(480, 1023))
                                                       : 10'($urandom_range(0, 479));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
